// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_pkg
// Purpose  : Shared definitions for the accumulation scheduler: default
//            field widths and the scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package acc_pkg;

    localparam int unsigned ACC_LEN_WIDTH_DEF  = 16;
    localparam int unsigned ACC_FCNT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } acc_state_e;

endpackage : acc_pkg
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
// Module   : rst_sync
// Purpose  : Reset synchroniser. Assertion propagates asynchronously,
//            release is retimed through two flops onto clk.
// Ports    : clk     - clock
//            rst_n_i - raw asynchronous active-low reset
//            rst_n_o - active-low reset, synchronous release
// Revision : 1.0 - initial release
// ============================================================================
module rst_sync (
    input  logic clk,
    input  logic rst_n_i,
    output logic rst_n_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_n_o = sync_q[1];

endmodule : rst_sync
`default_nettype wire

// File: rtl/acc_sched.sv
`default_nettype none
// ============================================================================
// Module   : acc_sched
// Purpose  : Integration scheduler for a downstream accumulator. Arms on
//            sync_in, opens an integration on the first valid sample, and
//            flags every integration boundary (acc_done_o) one cycle after
//            the sample strobe, marking partial integrations (discard_o).
// Ports    : clk, rst_n            - clock, async active-low reset
//            en                    - scheduler enable
//            sync_in               - arm / re-arm pulse
//            acc_len[LEN_WIDTH]    - samples per integration (0 acts as 1)
//            din_valid             - upstream sample strobe
//            valid_o               - din_valid delayed one cycle
//            acc_done_o            - first sample of a new integration
//            discard_o             - closing integration is partial
//            sample_idx[LEN_WIDTH] - index of the sample on valid_o
//            running               - scheduler is in RUN
//            frame_cnt[FCNT_WIDTH] - completed integrations (optional)
// Options  : ACC_SCHED_FCNT_EN - when defined, adds the frame_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module acc_sched
    import acc_pkg::*;
#(
    parameter int unsigned LEN_WIDTH  = ACC_LEN_WIDTH_DEF,
    parameter int unsigned FCNT_WIDTH = ACC_FCNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sync_in,
    input  logic [LEN_WIDTH-1:0]  acc_len,
    input  logic                  din_valid,
    output logic                  valid_o,
    output logic                  acc_done_o,
    output logic                  discard_o,
    output logic [LEN_WIDTH-1:0]  sample_idx,
    output logic                  running
`ifdef ACC_SCHED_FCNT_EN
    ,
    output logic [FCNT_WIDTH-1:0] frame_cnt
`endif
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    if (LEN_WIDTH < 1 || FCNT_WIDTH < 1) begin : g_param_check
        $error("acc_sched: LEN_WIDTH and FCNT_WIDTH must be at least 1");
    end

    logic rst_sync_n;

    rst_sync u_rst_sync (
        .clk     (clk),
        .rst_n_i (rst_n),
        .rst_n_o (rst_sync_n)
    );

    acc_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic                 valid_q;
    logic                 done_q, done_d;
    logic                 disc_q, disc_d;
    logic [LEN_WIDTH-1:0] len_eff;
    logic                 wrap;

    // A zero length would never reach its wrap point; treat it as one.
    assign len_eff = (acc_len == '0) ? LEN_ONE : acc_len;
    // cnt_q holds the index the next valid sample will carry.
    assign wrap    = (cnt_q == (len_q - LEN_ONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = '0;
        done_d  = 1'b0;
        disc_d  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            if (din_valid) begin
                idx_d = cnt_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sync_in) begin
                        state_d = ST_ARM;
                        len_d   = len_eff;
                    end
                end
                default: begin
                    // Re-arm wins over any boundary on the same sample, so the
                    // next valid sample reopens the integration as partial.
                    if (sync_in) begin
                        state_d = ST_ARM;
                        cnt_d   = '0;
                        len_d   = len_eff;
                    end else if (din_valid) begin
                        done_d  = (state_q == ST_ARM) || (cnt_q == '0);
                        disc_d  = (state_q == ST_ARM);
                        state_d = ST_RUN;
                        if (wrap) begin
                            cnt_d = '0;
                            len_d = len_eff;
                        end else begin
                            cnt_d = cnt_q + LEN_ONE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= LEN_ONE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            disc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            valid_q <= din_valid;
            done_q  <= done_d;
            disc_q  <= disc_d;
        end
    end

    assign valid_o    = valid_q;
    assign acc_done_o = done_q;
    assign discard_o  = disc_q;
    assign sample_idx = idx_q;
    assign running    = (state_q == ST_RUN);

`ifdef ACC_SCHED_FCNT_EN
    logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;

    // Counts only complete integrations; partial ones are skipped.
    always_comb begin
        fcnt_d = fcnt_q;
        if (state_d == ST_IDLE) begin
            fcnt_d = '0;
        end else if (done_d && !disc_d) begin
            fcnt_d = fcnt_q + FCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule : acc_sched
`default_nettype wire

// File: doc/acc_sched.md
ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16, width of integration-length and sample-index fields.
REQ-002 SHALL have parameter FCNT_WIDTH, default 32, width of the frame counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  scheduler enable.
REQ-006 SHALL have port sync_in  input  1  one-cycle pulse that arms or re-arms integration.
REQ-007 SHALL have port acc_len  input  LEN_WIDTH  samples per integration, unsigned; 0 treated as 1.
REQ-008 SHALL have port din_valid  input  1  upstream sample strobe.
REQ-009 SHALL have port valid_o  output  1  din_valid delayed one cycle, to drive accumulator din_valid.
REQ-010 SHALL have port acc_done_o  output  1  aligned with valid_o; marks first sample of a new integration.
REQ-011 SHALL have port discard_o  output  1  aligned with acc_done_o; the integration being closed is partial/invalid.
REQ-012 SHALL have port sample_idx  output  LEN_WIDTH  index of the sample on valid_o within its integration.
REQ-013 SHALL have port running  output  1  high in RUN state.

Function
REQ-014 SHALL implement states IDLE, ARM, RUN.
REQ-015 IDLE->ARM when en=1 and sync_in=1; ARM->RUN on first din_valid=1.
REQ-016 Any state->IDLE in the cycle after en=0; counters cleared, no acc_done_o issued.
REQ-017 sync_in=1 in RUN SHALL re-enter ARM; next valid sample gets acc_done_o=1, discard_o=1.
REQ-018 Latency din_valid->valid_o/acc_done_o/discard_o/sample_idx SHALL be exactly 1 cycle; upstream data must be delayed 1 cycle externally.
REQ-019 Sample in ARM producing RUN entry SHALL give acc_done_o=1, discard_o=1, sample_idx=0.
REQ-020 In RUN, internal counter SHALL increment per valid sample and wrap to 0 at len_q-1; wrap sample gives acc_done_o=1, discard_o=0, sample_idx=0.
REQ-021 len_q SHALL be sampled from acc_len on ARM entry and at every wrap; acc_len changes mid-integration have no effect until next boundary.
REQ-022 len_q=1 SHALL assert acc_done_o on every valid sample after the first.
REQ-023 din_valid=0 cycles SHALL freeze all counters; acc_done_o, discard_o SHALL be 0 whenever valid_o=0.
REQ-024 sync_in simultaneous with wrap in RUN SHALL take re-arm priority: that sample gets no acc_done_o, next valid sample gets acc_done_o=1, discard_o=1.
REQ-025 sync_in with en=0 SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, len_q=1, counters 0, valid_o=0, acc_done_o=0, discard_o=0, sample_idx=0, running=0, frame_cnt=0.
REQ-027 Reset deassertion SHALL be synchronised internally before use (two-flop release).
REQ-028 Reset mid-integration SHALL discard all state; no acc_done_o until new sync_in.

Configuration
REQ-029 Macro ACC_SCHED_FCNT_EN defined SHALL add output frame_cnt [FCNT_WIDTH-1:0], incremented (wrapping) on each acc_done_o with discard_o=0, cleared on IDLE.
REQ-030 ACC_SCHED_FCNT_EN undefined SHALL omit frame_cnt port and logic; all other behaviour identical.

Structure
REQ-031 State encoding typedef and default LEN_WIDTH/FCNT_WIDTH constants SHALL live in shared package acc_pkg.
REQ-032 Reset release synchroniser SHALL be sub-module rst_sync; counter/FSM stay in acc_sched.
REQ-033 RTL target 120-400 lines; no multipliers, no memories.

Verification
REQ-034 acc_len=4, sync then 9 continuous valids -> acc_done_o on samples 1(discard=1),5,9(discard=0); sample_idx 0,1,2,3,0,...
REQ-035 acc_len=3, valids gapped every other cycle -> acc_done_o only on valid_o cycles, on samples 1,4,7; counts unaffected by gaps.
REQ-036 acc_len 4->2 written at sample 2 -> boundary at 5 unchanged, then boundaries at 7,9.
REQ-037 sync_in at sample 6 (acc_len=4) -> sample 7 acc_done_o=1, discard_o=1, sample_idx=0; frame_cnt unchanged.
REQ-038 rst_n low mid-integration then en=1 without sync_in -> running=0, no acc_done_o; frame_cnt=0.
REQ-039 acc_len=0 -> behaves as 1; with ACC_SCHED_FCNT_EN, 5 valids -> frame_cnt=4.
